dff_stim_chk: RTL

Synthesizable stimulus driver and checker for the 4-bit D flip-flop DUT; it sits on the programme end of the DFF interface, opposite the DUT. On `start` it pulses the DUT reset and drives a pseudo-random data sequence. Each cycle it compares the DUT's registered output against a one-cycle-delayed reference model, then reports pass/fail with error count and first-failure capture. It replaces the behavioural test programme in regressions and on-board self-test.

---
 rtl/dff_chk_pkg.sv | 38 +++
 rtl/dff_stim_chk_if.sv | 21 ++
 rtl/dff_chk_lfsr.sv | 34 +++
 rtl/dff_stim_chk.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/dff_chk_pkg.sv
// Shared types, constants and LFSR helpers for the DFF stimulus driver/checker.
// Optional reset-priority probe is enabled by defining DFF_CHK_MIDRST_EN.
package dff_chk_pkg;

   localparam int              LFSR_W    = 8;
   localparam int              ERR_CNT_W = 8;
   localparam logic [LFSR_W-1:0] LFSR_POLY = 8'hB8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RESET = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } chk_state_t;

   // Right-shifting Galois step for x^8+x^6+x^5+x^4+1
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      logic [LFSR_W-1:0] nxt;
      if (s[0]) begin
         nxt = (s >> 1) ^ LFSR_POLY;
      end else begin
         nxt = s >> 1;
      end
      return nxt;
   endfunction

   function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
      logic [LFSR_W-1:0] fixed;
      if (s == {LFSR_W{1'b0}}) begin
         fixed = 8'h01;
      end else begin
         fixed = s;
      end
      return fixed;
   endfunction

endpackage

// File: rtl/dff_stim_chk_if.sv
// DFF bus between the stimulus/checker (master) and the flip-flop under test (slave).
// No build options affect this file.
interface dff_stim_chk_if #(
   parameter int W = 4
);
   logic         drv_rst;
   logic [W-1:0] drv_d;
   logic [W-1:0] dut_q;

   modport master (
      output drv_rst,
      output drv_d,
      input  dut_q
   );

   modport slave (
      input  drv_rst,
      input  drv_d,
      output dut_q
   );
endinterface

// File: rtl/dff_chk_lfsr.sv
// 8-bit Galois LFSR with seed load and advance; a zero seed is replaced by 8'h01.
// No build options affect this file.
module dff_chk_lfsr
   import dff_chk_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED  = 8'hA5,
   parameter int                OUT_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic [LFSR_W-1:0] i_seed,
   input  logic              i_adv,
   output logic [OUT_W-1:0]  o_state
);

   logic [LFSR_W-1:0] r_state;

   // Load has priority over advance so a restart always begins at the seed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= seed_fix(SEED);
      end else if (i_load) begin
         r_state <= seed_fix(i_seed);
      end else if (i_adv) begin
         r_state <= lfsr_step(r_state);
      end else begin
         r_state <= r_state;
      end
   end

   assign o_state = r_state[OUT_W-1:0];

endmodule

// File: rtl/dff_stim_chk.sv
// Stimulus driver and checker for a W-bit D flip-flop: reset pulse, LFSR data, scoreboard.
// Define DFF_CHK_MIDRST_EN to pulse the DUT reset once mid-run (reset-over-data probe).
module dff_stim_chk
   import dff_chk_pkg::*;
#(
   parameter int          W       = 4,
   parameter int          NUM_VEC = 16,
   parameter int          RST_CYC = 2,
   parameter logic [7:0]  SEED    = 8'hA5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   dff_stim_chk_if.master       bus,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic [7:0]           first_err_idx,
   output logic [W-1:0]         first_err_q
);

   localparam logic [7:0] L_RST_LAST = 8'(RST_CYC - 1);
   localparam logic [7:0] L_VEC_LAST = 8'(NUM_VEC - 1);
`ifdef DFF_CHK_MIDRST_EN
   localparam logic [7:0] L_MID      = 8'(NUM_VEC / 2);
`endif

   chk_state_t           r_state;
   logic [7:0]           r_cnt;
   logic                 r_drv_rst;
   logic [W-1:0]         r_drv_d;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_pass;
   logic                 r_cmp_en;
   logic [W-1:0]         r_exp_q;
   logic [7:0]           r_cmp_idx;
   logic [ERR_CNT_W-1:0] r_err_cnt;
   logic [7:0]           r_first_idx;
   logic [W-1:0]         r_first_q;

   logic                 w_start_acc;
   logic                 w_mismatch;
   logic [ERR_CNT_W-1:0] w_err_cnt_nxt;
   logic                 w_lfsr_adv;
   logic [W-1:0]         w_lfsr;

   dff_chk_lfsr #(
      .SEED  (SEED),
      .OUT_W (W)
   ) u_lfsr (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_start_acc),
      .i_seed  (SEED),
      .i_adv   (w_lfsr_adv),
      .o_state (w_lfsr)
   );

   assign w_start_acc = start && ((r_state == IDLE) || (r_state == DONE));
   assign w_mismatch  = r_cmp_en && (bus.dut_q != r_exp_q);

   // Saturating next error count, shared by scoreboard and the pass verdict
   always_comb begin
      w_err_cnt_nxt = r_err_cnt;
      if (w_mismatch && (r_err_cnt != 8'hFF)) begin
         w_err_cnt_nxt = r_err_cnt + 8'd1;
      end else begin
         w_err_cnt_nxt = r_err_cnt;
      end
   end

   // The LFSR steps whenever a fresh vector is handed to drv_d
   always_comb begin
      w_lfsr_adv = 1'b0;
      if (r_state == RESET) begin
         w_lfsr_adv = (r_cnt == L_RST_LAST);
      end else if (r_state == RUN) begin
         w_lfsr_adv = (r_cnt != L_VEC_LAST);
      end else begin
         w_lfsr_adv = 1'b0;
      end
   end

   // Sequencer: outputs are set on the edge that enters each state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_cnt     <= 8'd0;
         r_drv_rst <= 1'b0;
         r_drv_d   <= {W{1'b0}};
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_pass    <= 1'b0;
         r_cmp_en  <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_state   <= RESET;
                  r_cnt     <= 8'd0;
                  r_drv_rst <= 1'b1;
                  r_drv_d   <= {W{1'b0}};
                  r_busy    <= 1'b1;
                  r_done    <= 1'b0;
                  r_pass    <= 1'b0;
               end
            end
            RESET: begin
               if (r_cnt == L_RST_LAST) begin
                  r_state   <= RUN;
                  r_cnt     <= 8'd0;
                  r_drv_rst <= 1'b0;
                  r_drv_d   <= w_lfsr;
                  r_cmp_en  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            RUN: begin
               if (r_cnt == L_VEC_LAST) begin
                  r_state   <= DRAIN;
                  r_drv_rst <= 1'b0;
                  r_drv_d   <= {W{1'b0}};
               end else begin
                  r_cnt   <= r_cnt + 8'd1;
                  r_drv_d <= w_lfsr;
`ifdef DFF_CHK_MIDRST_EN
                  r_drv_rst <= ((r_cnt + 8'd1) == L_MID);
`else
                  r_drv_rst <= 1'b0;
`endif
               end
            end
            DRAIN: begin
               // Last compare happens on this same edge, so judge on the next count
               r_state  <= DONE;
               r_cmp_en <= 1'b0;
               r_busy   <= 1'b0;
               r_done   <= 1'b1;
               r_pass   <= (w_err_cnt_nxt == 8'd0);
            end
            default: begin
               r_state   <= IDLE;
               r_cnt     <= 8'd0;
               r_drv_rst <= 1'b0;
               r_drv_d   <= {W{1'b0}};
               r_busy    <= 1'b0;
               r_done    <= 1'b0;
               r_pass    <= 1'b0;
               r_cmp_en  <= 1'b0;
            end
         endcase
      end
   end

   // Reference model and scoreboard with first-failure capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_exp_q     <= {W{1'b0}};
         r_cmp_idx   <= 8'd0;
         r_err_cnt   <= 8'd0;
         r_first_idx <= 8'd0;
         r_first_q   <= {W{1'b0}};
      end else begin
         r_exp_q <= r_drv_rst ? {W{1'b0}} : r_drv_d;
         if (w_start_acc) begin
            r_cmp_idx   <= 8'd0;
            r_err_cnt   <= 8'd0;
            r_first_idx <= 8'd0;
            r_first_q   <= {W{1'b0}};
         end else if (r_cmp_en) begin
            r_cmp_idx <= r_cmp_idx + 8'd1;
            r_err_cnt <= w_err_cnt_nxt;
            if (w_mismatch && (r_err_cnt == 8'd0)) begin
               r_first_idx <= r_cmp_idx;
               r_first_q   <= bus.dut_q;
            end
         end
      end
   end

   assign bus.drv_rst    = r_drv_rst;
   assign bus.drv_d      = r_drv_d;
   assign busy           = r_busy;
   assign done           = r_done;
   assign pass           = r_pass;
   assign err_cnt        = r_err_cnt;
   assign first_err_idx  = r_first_idx;
   assign first_err_q    = r_first_q;

endmodule
